// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit positions, the hex glyph table
// used by both the driver and the scan reader, and the reader's output states.
package seg7_pkg;

    localparam int SEG_W = 7;

    typedef enum int {
        SEG_A = 0,
        SEG_B = 1,
        SEG_C = 2,
        SEG_D = 3,
        SEG_E = 4,
        SEG_F = 5,
        SEG_G = 6
    } seg_bit_e;

    // Glyphs for 0..F, active-high, bit0 = a ... bit6 = g
    localparam logic [SEG_W-1:0] HEX_TO_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Reverse glyph lookup: maps a segment pattern back to its hex nibble and
// flags any pattern that is not one of the sixteen hex glyphs.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [3:0]       nibble,
    output logic             invalid
);

    // Glyphs are unique, so at most one table entry can match
    always_comb begin
        nibble  = '0;
        invalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (seg == HEX_TO_SEG[i]) begin
                nibble  = 4'(i);
                invalid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers hex digits from a multiplexed 7-segment bus: debounces each digit
// dwell, assembles a full frame and offers it on a valid/ready output.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEG_W-1:0]      seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   out_value,
    output logic                  out_err,
    output logic                  out_overrun
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(STABLE_CYCLES - 2);

    logic [SEG_W-1:0]    s_seg;
    logic [DIGITS-1:0]   s_dig;
    logic [CNT_W-1:0]    stable_cnt;
    logic [DIGITS-1:0]   cap_mask;
    logic [DIGITS-1:0]   slot_err;
    logic [4*DIGITS-1:0] slot_value;
    logic [3:0]          dec_nibble;
    logic                dec_invalid;
    logic                sample_match;
    logic                accept;
    logic                frame_done;
    out_state_t          state;
    out_state_t          state_next;
    logic                load_out;
    logic                drop_frame;

    seg7_to_hex u_decode (
        .seg     (seg_in),
        .nibble  (dec_nibble),
        .invalid (dec_invalid)
    );

    assign sample_match = (seg_in == s_seg) && (dig_sel == s_dig) && $onehot(dig_sel);
    // The counter passes STABLE_CYCLES-2 only once per dwell, so accept fires once
    assign accept       = sample_match && (stable_cnt == CNT_ACCEPT);
    assign frame_done   = &cap_mask;
    assign out_valid    = (state == FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            s_seg      <= '0;
            s_dig      <= '0;
            stable_cnt <= '0;
        end else begin
            s_seg <= seg_in;
            s_dig <= dig_sel;
            if (!sample_match) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

    // A completed frame is cleared first so an acceptance on the same edge starts the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_mask   <= '0;
            slot_value <= '0;
            slot_err   <= '0;
        end else begin
            if (frame_done) begin
                cap_mask   <= '0;
                slot_value <= '0;
                slot_err   <= '0;
            end
            if (accept) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (dig_sel[i]) begin
                        cap_mask[i]        <= 1'b1;
                        slot_value[4*i +: 4] <= dec_nibble;
                        slot_err[i]        <= dec_invalid;
                    end
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        drop_frame = 1'b0;
        case (state)
            EMPTY: begin
                if (frame_done) begin
                    load_out   = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (frame_done) begin
                    load_out   = out_ready;
                    drop_frame = !out_ready;
                end else if (out_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            out_value   <= '0;
            out_err     <= 1'b0;
            out_overrun <= 1'b0;
        end else begin
            state       <= state_next;
            out_overrun <= drop_frame;
            if (load_out) begin
                out_value <= slot_value;
                out_err   <= |slot_err;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed self-checking bench for seg7_scan_reader (DIGITS=4, STABLE_CYCLES=3).
module tb_seg7_scan_reader;

    logic        clk;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_value;
    logic        out_err;
    logic        out_overrun;

    int checks = 0;
    int passes = 0;
    int valid_cycles = 0;
    int hs_count = 0;
    int ovr_count = 0;
    logic [15:0] hs_value = '0;
    logic        hs_err = 1'b0;

    seg7_scan_reader #(
        .DIGITS        (4),
        .STABLE_CYCLES (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_value   (out_value),
        .out_err     (out_err),
        .out_overrun (out_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observes handshakes and overrun pulses mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (out_valid) valid_cycles <= valid_cycles + 1;
        if (out_valid && out_ready) begin
            hs_count <= hs_count + 1;
            hs_value <= out_value;
            hs_err   <= out_err;
        end
        if (out_overrun) ovr_count <= ovr_count + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
        seg_in  = s;
        dig_sel = d;
        step(n);
    endtask

    task automatic scan_digit(input logic [6:0] s, input int idx, input int n);
        drive(s, 4'(1 << idx), n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        drive(7'h00, 4'b0000, 3);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b, expected 0", out_valid); else passes++;
        checks++; if (out_value !== 16'h0000) $display("[TB] FAIL reset_value: got %h, expected 0000", out_value); else passes++;
        checks++; if (out_err !== 1'b0) $display("[TB] FAIL reset_err: got %b, expected 0", out_err); else passes++;
        checks++; if (out_overrun !== 1'b0) $display("[TB] FAIL reset_overrun: got %b, expected 0", out_overrun); else passes++;
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_scan();
        int hs0 = hs_count;
        int v0  = valid_cycles;
        out_ready = 1'b1;
        scan_digit(7'h4F, 0, 4);
        scan_digit(7'h66, 1, 4);
        scan_digit(7'h6D, 2, 4);
        scan_digit(7'h7D, 3, 4);
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL scan_valid: got %b, expected 1", out_valid); else passes++;
        checks++; if (out_value !== 16'h6543) $display("[TB] FAIL scan_value: got %h, expected 6543", out_value); else passes++;
        checks++; if (out_err !== 1'b0) $display("[TB] FAIL scan_err: got %b, expected 0", out_err); else passes++;
        drive(7'h00, 4'b0000, 3);
        checks++; if (hs_count - hs0 !== 1) $display("[TB] FAIL scan_handshakes: got %0d, expected 1", hs_count - hs0); else passes++;
        checks++; if (valid_cycles - v0 !== 1) $display("[TB] FAIL scan_valid_cycles: got %0d, expected 1", valid_cycles - v0); else passes++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL scan_valid_drop: got %b, expected 0", out_valid); else passes++;
    endtask

    task automatic test_glitch();
        int hs0 = hs_count;
        scan_digit(7'h3F, 0, 4);
        scan_digit(7'h06, 1, 4);
        scan_digit(7'h5B, 2, 4);
        scan_digit(7'h7F, 2, 1);
        scan_digit(7'h5B, 2, 4);
        scan_digit(7'h7F, 2, 2);
        scan_digit(7'h5B, 2, 4);
        scan_digit(7'h4F, 3, 4);
        drive(7'h00, 4'b0000, 3);
        checks++; if (hs_count - hs0 !== 1) $display("[TB] FAIL glitch_handshakes: got %0d, expected 1", hs_count - hs0); else passes++;
        checks++; if (hs_value !== 16'h3210) $display("[TB] FAIL glitch_value: got %h, expected 3210", hs_value); else passes++;
        checks++; if (hs_err !== 1'b0) $display("[TB] FAIL glitch_err: got %b, expected 0", hs_err); else passes++;
    endtask

    task automatic test_invalid();
        int hs0 = hs_count;
        scan_digit(7'h3F, 0, 4);
        scan_digit(7'h55, 1, 4);
        scan_digit(7'h5B, 2, 4);
        scan_digit(7'h4F, 3, 4);
        drive(7'h00, 4'b0000, 3);
        checks++; if (hs_count - hs0 !== 1) $display("[TB] FAIL invalid_handshakes: got %0d, expected 1", hs_count - hs0); else passes++;
        checks++; if (hs_value !== 16'h3200) $display("[TB] FAIL invalid_value: got %h, expected 3200", hs_value); else passes++;
        checks++; if (hs_err !== 1'b1) $display("[TB] FAIL invalid_err: got %b, expected 1", hs_err); else passes++;
    endtask

    task automatic test_overrun();
        int hs0  = hs_count;
        int ovr0 = ovr_count;
        out_ready = 1'b0;
        scan_digit(7'h66, 0, 4);
        scan_digit(7'h4F, 1, 4);
        scan_digit(7'h5B, 2, 4);
        scan_digit(7'h06, 3, 4);
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL ovr_first_valid: got %b, expected 1", out_valid); else passes++;
        checks++; if (out_value !== 16'h1234) $display("[TB] FAIL ovr_first_value: got %h, expected 1234", out_value); else passes++;
        scan_digit(7'h5E, 0, 4);
        scan_digit(7'h39, 1, 4);
        scan_digit(7'h7C, 2, 4);
        scan_digit(7'h77, 3, 4);
        drive(7'h00, 4'b0000, 3);
        checks++; if (ovr_count - ovr0 !== 1) $display("[TB] FAIL ovr_pulses: got %0d, expected 1", ovr_count - ovr0); else passes++;
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL ovr_held_valid: got %b, expected 1", out_valid); else passes++;
        checks++; if (out_value !== 16'h1234) $display("[TB] FAIL ovr_held_value: got %h, expected 1234", out_value); else passes++;
        out_ready = 1'b1;
        step(1);
        checks++; if (hs_value !== 16'h1234) $display("[TB] FAIL ovr_drain_value: got %h, expected 1234", hs_value); else passes++;
        checks++; if (hs_count - hs0 !== 1) $display("[TB] FAIL ovr_handshakes: got %0d, expected 1", hs_count - hs0); else passes++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL ovr_valid_drop: got %b, expected 0", out_valid); else passes++;
        step(2);
    endtask

    task automatic test_back_to_back();
        int hs0  = hs_count;
        int ovr0 = ovr_count;
        out_ready = 1'b0;
        scan_digit(7'h7F, 0, 4);
        scan_digit(7'h07, 1, 4);
        scan_digit(7'h7D, 2, 4);
        scan_digit(7'h6D, 3, 4);
        scan_digit(7'h39, 0, 4);
        scan_digit(7'h7C, 1, 4);
        scan_digit(7'h77, 2, 4);
        scan_digit(7'h6F, 3, 3);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL b2b_valid: got %b, expected 1", out_valid); else passes++;
        checks++; if (out_value !== 16'h9ABC) $display("[TB] FAIL b2b_value: got %h, expected 9abc", out_value); else passes++;
        checks++; if (hs_value !== 16'h5678) $display("[TB] FAIL b2b_first_taken: got %h, expected 5678", hs_value); else passes++;
        drive(7'h00, 4'b0000, 3);
        checks++; if (ovr_count - ovr0 !== 0) $display("[TB] FAIL b2b_overrun: got %0d, expected 0", ovr_count - ovr0); else passes++;
        out_ready = 1'b1;
        step(2);
        checks++; if (hs_count - hs0 !== 2) $display("[TB] FAIL b2b_handshakes: got %0d, expected 2", hs_count - hs0); else passes++;
        checks++; if (hs_value !== 16'h9ABC) $display("[TB] FAIL b2b_second_taken: got %h, expected 9abc", hs_value); else passes++;
    endtask

    task automatic test_select_and_reset();
        int hs0 = hs_count;
        out_ready = 1'b1;
        drive(7'h3F, 4'b0000, 10);
        drive(7'h3F, 4'b0011, 10);
        scan_digit(7'h5B, 2, 4);
        scan_digit(7'h4F, 3, 4);
        step(3);
        checks++; if (hs_count - hs0 !== 0) $display("[TB] FAIL badsel_no_frame: got %0d frames, expected 0", hs_count - hs0); else passes++;
        scan_digit(7'h06, 0, 4);
        scan_digit(7'h66, 1, 4);
        drive(7'h00, 4'b0000, 3);
        checks++; if (hs_value !== 16'h3241) $display("[TB] FAIL badsel_value: got %h, expected 3241", hs_value); else passes++;
        hs0 = hs_count;
        scan_digit(7'h7F, 0, 4);
        scan_digit(7'h07, 1, 4);
        scan_digit(7'h7D, 2, 4);
        rst = 1'b1;
        drive(7'h00, 4'b0000, 2);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL rst_mid_valid: got %b, expected 0", out_valid); else passes++;
        rst = 1'b0;
        scan_digit(7'h6D, 3, 4);
        drive(7'h00, 4'b0000, 4);
        checks++; if (hs_count - hs0 !== 0) $display("[TB] FAIL rst_mid_no_frame: got %0d frames, expected 0", hs_count - hs0); else passes++;
        scan_digit(7'h3F, 0, 4);
        scan_digit(7'h06, 1, 4);
        scan_digit(7'h5B, 2, 4);
        drive(7'h00, 4'b0000, 3);
        checks++; if (hs_count - hs0 !== 1) $display("[TB] FAIL rst_new_frame: got %0d frames, expected 1", hs_count - hs0); else passes++;
        checks++; if (hs_value !== 16'h5210) $display("[TB] FAIL rst_new_value: got %h, expected 5210", hs_value); else passes++;
    endtask

    initial begin
        rst       = 1'b1;
        seg_in    = '0;
        dig_sel   = '0;
        out_ready = 1'b0;
        test_reset();
        test_scan();
        test_glitch();
        test_invalid();
        test_overrun();
        test_back_to_back();
        test_select_and_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Receive-side counterpart of the hex-to-7-segment driver: watches a time-multiplexed multi-digit 7-segment bus (segment pattern plus one-hot digit select) and recovers the hex nibbles being displayed.
- Filters glitches with a stability window and assembles one full frame (all digits).
- Presents the frame on a valid/ready output with a per-frame invalid-pattern flag.
- Sits between the display scan logic and any checker or consumer that needs the displayed value back as binary.

Parameters:
- DIGITS, 4, number of multiplexed digits; frame width is 4*DIGITS bits.
- STABLE_CYCLES, 3, consecutive identical samples (segment and select) required to accept a digit; legal range 2..15.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- seg_in  input  7  segment pattern, active-high, bit0=a … bit6=g.
- dig_sel  input  DIGITS  one-hot digit select; bit i means seg_in belongs to digit i (digit 0 = least significant nibble).
- out_ready  input  1  consumer accepts the frame when high together with out_valid.
- out_valid  output  1  frame available.
- out_value  output  4*DIGITS  recovered nibbles; digit i in bits [4i+3:4i].
- out_err  output  1  at least one digit in the frame was an undecodable pattern.
- out_overrun  output  1  one-cycle pulse: a completed frame was dropped.

Behaviour:
- Reset values: out_valid=0, out_value=0, out_err=0, out_overrun=0; capture mask, stability counter and sample registers all cleared. Reset mid-frame or mid-hold discards everything, with no output pulse.
- Sampling: seg_in/dig_sel registered every edge (s_seg, s_dig).
- Stability counter: increments, saturating at STABLE_CYCLES, when the raw input equals {s_seg,s_dig} and dig_sel is one-hot. It resets to 0 otherwise, including when dig_sel is zero or multi-hot.
- Acceptance:
  - A digit is accepted exactly once per dwell, on the edge where the counter reaches STABLE_CYCLES-1.
  - The decoded nibble and invalid flag are written into that digit's slot, and its mask bit is set.
  - Re-acceptance of an already-captured digit before the frame completes overwrites the slot (last wins).
- Decode: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71 (hex codes of seg_in). Any other pattern gives nibble 0 and sets the invalid flag.
- Frame completion: the cycle after the mask becomes all-ones, the frame is complete. Frame data and OR-of-invalid flags are offered to the output stage, and the mask and slots are cleared.
- Latency: a pattern present before edge k and held through edge k+STABLE_CYCLES-1 is accepted at that edge. If it completes the frame, out_valid is high after edge k+STABLE_CYCLES.
- Output FSM, two states:
  - EMPTY: out_valid=0. On frame completion, load out_value/out_err and go to FULL.
  - FULL: out_valid=1; out_value and out_err are held stable.
    - out_ready=1 with no new frame: go to EMPTY.
    - out_ready=1 with a simultaneous frame completion: load the new frame and stay FULL, with no overrun.
    - out_ready=0 with a frame completion: drop the new frame, pulse out_overrun for 1 cycle, keep the old data.
- Collection continues in both states; the consumer never stalls the capture path.
- Width rules: the stability counter is $clog2(STABLE_CYCLES+1) bits; the mask is DIGITS bits; no arithmetic beyond the counter.

Decomposition:
- Package seg7_pkg:
  - SEG_W=7 and segment bit-index constants.
  - The 16-entry hex-to-pattern constant array, shared with the driver side.
  - The output FSM state enum {EMPTY, FULL}.
- Sub-module seg7_to_hex: combinational pattern to {nibble, invalid}, built from the package array; one instance.
- Everything else (sampling, stability, mask, output FSM) lives in seg7_scan_reader.

Test Plan:
- Scan digits 0..3 with 4F,66,6D,7D, each held 4 cycles, out_ready=1 → single out_valid pulse, out_value=16'h6543, out_err=0, handshake on the first valid cycle.
- 1-cycle and 2-cycle glitch pattern 7F on digit 2 between stable dwells of 5B → glitch ignored, nibble 2=0x2.
- Digit 1 driven 0x55 (invalid) in an otherwise valid frame 3F,06,5B,4F → out_value=16'h3200, out_err=1.
- Two complete frames (16'h1234 then 16'hABCD) with out_ready=0 → first frame held; one out_overrun pulse on the second completion; after ready=1, 16'h1234 is accepted and out_valid drops.
- Frame completes on the same edge as the handshake (ready=1) → out_valid stays 1, the new value appears, no overrun.
- dig_sel=4'b0000 and 4'b0011 held 10 cycles → no capture; rst asserted with 3 of 4 digits captured → after release, a full new frame is required before out_valid.
